data_memory_mc: RTL
===================

// Module: data_memory_mc
// PURPOSE
//  Multi-channel game-state RAM. Generalises the single-input data memory to NUM_IN input channels and NUM_WIN window read ports.
//  Adds a hardware clear sequencer, per-channel change (dirty) flags and write-drop reporting.
//  Sits between the game CPU (regular port), the input conditioners (in_* channels) and the display and score logic (win_read, flag_read).
// PARAMETERS
//  SIZE        16                   bits per entry
//  DEPTH       64                   number of entries; AW = $clog2(DEPTH)
//  NUM_IN      2                    number of input write channels
//  IN_ADDRS    {6'd29,6'd0}         packed NUM_IN*AW; channel i address = IN_ADDRS[i*AW+:AW]
//  NUM_WIN     3                    number of window read ports
//  WIN_LEN     9                    entries per window
//  WIN_STARTS  {6'd10,6'd19,6'd1}   packed NUM_WIN*AW; window w start address
//  FLAG_ADDR   28                   address whose bit 0 drives flag_read
//  CLEAR_VAL   0                    SIZE-bit value written by the clear sequencer
// PORTS
//  clk           in   1                  clock; all state updates on posedge
//  rst           in   1                  synchronous, active-high reset
//  clear_req     in   1                  request a full-memory clear (1-cycle pulse sufficient)
//  busy          out  1                  1 while the clear sequencer runs
//  write_drop    out  1                  1-cycle pulse: write_en was high while busy (write discarded)
//  waddr         in   AW                 regular write address
//  write_data    in   SIZE               regular write data
//  write_en      in   1                  regular write enable
//  raddr         in   AW                 regular read address
//  read_data     out  SIZE               mem[raddr], combinational
//  in_data       in   NUM_IN*SIZE        channel i write data at [i*SIZE+:SIZE]
//  in_en         in   NUM_IN             channel i write enable
//  in_read       out  NUM_IN*SIZE        mem[IN_ADDRS[i]], combinational
//  in_dirty      out  NUM_IN             sticky: channel i committed a changed value
//  in_dirty_clr  in   NUM_IN             clear in_dirty[i]
//  win_read      out  NUM_WIN*WIN_LEN*SIZE  window w entry j at [(w*WIN_LEN+j)*SIZE+:SIZE] = mem[(start_w+j) mod DEPTH]
//  flag_read     out  1                  mem[FLAG_ADDR][0]
// BEHAVIOUR
//  FSM states: IDLE, CLEAR. Counter clr_cnt is AW bits wide.
//  rst high at an edge: state<=CLEAR, clr_cnt<=0, in_dirty<=0, write_drop<=0. No memory write occurs while rst is high.
//  CLEAR, rst low: write mem[clr_cnt]<=CLEAR_VAL and increment clr_cnt. At clr_cnt==DEPTH-1, go to IDLE.
//   After rst deasserts, busy stays high for exactly DEPTH edges. From then on every read returns CLEAR_VAL.
//  IDLE, clear_req=1: next state CLEAR, clr_cnt<=0, in_dirty<=0. clear_req is ignored while in CLEAR (no restart).
//  rst during CLEAR: the sequence restarts at address 0.
//  busy = (state==CLEAR), registered. Reset value is 1.
//  While busy, all regular and channel writes are discarded. write_drop<=write_en&busy. Channels do not report a drop.
//  IDLE write precedence at a single edge:
//   - A regular write always commits.
//   - Channel i commits unless a regular write targets the same address, or a lower-index channel with the same address commits.
//  in_dirty[i] is set on an edge where channel i commits and in_data_i != the old mem value.
//   Set beats in_dirty_clr[i] on the same edge. Otherwise in_dirty_clr[i] clears the flag.
//  Reads are combinational from the array, with zero latency. A write is visible on read outputs the cycle after its edge.
//  Out-of-range addresses (DEPTH not a power of 2):
//   - waddr>=DEPTH: the write is ignored.
//   - raddr>=DEPTH: read_data=CLEAR_VAL.
//  Window indices wrap modulo DEPTH.
//  During and before the first clear the read outputs are undefined. Do not check them until busy falls.
// TESTING
//  1. rst 1 cycle, then idle -> busy=1 for 64 edges then 0; read of addresses 0..63 = 0; in_dirty=0.
//  2. IDLE, write_en waddr=0 data=5, in_en[0] data=7 same edge -> mem[0]=5; in_dirty[0]=0. Next edge in_en[0] data=7 -> mem[0]=7, in_dirty[0]=1.
//  3. in_en[1] data=3 twice, then data=3 with in_dirty_clr[1] -> in_dirty[1] set after first, stays low after clr; simultaneous set+clr (new value 4) -> in_dirty[1]=1.
//  4. clear_req at cycle 5 of IDLE, write_en every cycle -> busy 64 cycles, write_drop high each busy cycle, all mem=0; clear_req during busy has no effect.
//  5. rst at clr_cnt=30 -> clr_cnt restarts at 0, busy high 64 further edges after rst low.
//  6. WIN_STARTS w0=60, WIN_LEN=9 -> win_read entries 0..8 map to addresses 60,61,62,63,0,1,2,3,4; write mem[28]=16'h0001 -> flag_read=1.

Source files
------------

// File: rtl/data_memory_mc_if.sv
// Bus bundle for the multi-channel game-state RAM: CPU port, input
// channels, window/flag read-outs and the clear sequencer handshake.
interface data_memory_mc_if #(
    parameter int SIZE    = 16,
    parameter int DEPTH   = 64,
    parameter int NUM_IN  = 2,
    parameter int NUM_WIN = 3,
    parameter int WIN_LEN = 9
);
    localparam int AW = $clog2(DEPTH);

    logic                              clear_req;
    logic                              busy;
    logic                              write_drop;
    logic [AW-1:0]                     waddr;
    logic [SIZE-1:0]                   write_data;
    logic                              write_en;
    logic [AW-1:0]                     raddr;
    logic [SIZE-1:0]                   read_data;
    logic [NUM_IN*SIZE-1:0]            in_data;
    logic [NUM_IN-1:0]                 in_en;
    logic [NUM_IN*SIZE-1:0]            in_read;
    logic [NUM_IN-1:0]                 in_dirty;
    logic [NUM_IN-1:0]                 in_dirty_clr;
    logic [NUM_WIN*WIN_LEN*SIZE-1:0]   win_read;
    logic                              flag_read;

    modport slave (
        input  clear_req, waddr, write_data, write_en, raddr,
               in_data, in_en, in_dirty_clr,
        output busy, write_drop, read_data, in_read, in_dirty,
               win_read, flag_read
    );

    modport master (
        output clear_req, waddr, write_data, write_en, raddr,
               in_data, in_en, in_dirty_clr,
        input  busy, write_drop, read_data, in_read, in_dirty,
               win_read, flag_read
    );
endinterface

// File: rtl/data_memory_mc.sv
// Multi-channel game-state RAM with a hardware clear sequencer,
// per-channel dirty flags and write-drop reporting.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | normal operation; CPU and channel writes commit
// CLEAR | sweeping CLEAR_VAL over every entry; all writes discarded
module data_memory_mc #(
    parameter int SIZE    = 16,
    parameter int DEPTH   = 64,
    parameter int NUM_IN  = 2,
    parameter logic [NUM_IN*$clog2(DEPTH)-1:0] IN_ADDRS = {6'd29, 6'd0},
    parameter int NUM_WIN = 3,
    parameter int WIN_LEN = 9,
    parameter logic [NUM_WIN*$clog2(DEPTH)-1:0] WIN_STARTS = {6'd10, 6'd19, 6'd1},
    parameter int FLAG_ADDR = 28,
    parameter logic [SIZE-1:0] CLEAR_VAL = '0
) (
    input  logic               clk,
    input  logic               rst,
    data_memory_mc_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [AW-1:0]       r_clr_cnt;
    logic [SIZE-1:0]     r_mem [DEPTH];
    logic [NUM_IN-1:0]   r_dirty;
    logic                r_write_drop;
    logic                w_busy;
    logic                w_reg_we;
    logic [NUM_IN-1:0]   w_ch_commit;
    logic [NUM_IN-1:0]   w_dirty_set;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (DEPTH == (1 << AW)) || (int'(a) < DEPTH);
    endfunction

    function automatic logic [AW-1:0] ch_addr(input int i);
        return IN_ADDRS[i*AW +: AW];
    endfunction

    assign w_busy = (r_state == CLEAR);

    // FSM state register; reset always (re)starts a clear sweep
    always_ff @(posedge clk) begin
        if (rst) r_state <= CLEAR;
        else     r_state <= w_state_next;
    end

    // FSM next state: clear_req only honoured from IDLE, so no restart mid-sweep
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.clear_req) w_state_next = CLEAR;
            CLEAR:   if (r_clr_cnt == LAST_ADDR) w_state_next = IDLE;
            default: w_state_next = CLEAR;
        endcase
    end

    // Clear sweep address counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_cnt <= '0;
        end else if (r_state == IDLE && bus.clear_req) begin
            r_clr_cnt <= '0;
        end else if (r_state == CLEAR) begin
            r_clr_cnt <= (r_clr_cnt == LAST_ADDR) ? '0 : r_clr_cnt + AW'(1);
        end
    end

    // Write arbitration: CPU write wins, then the lowest-index channel per address
    always_comb begin
        w_reg_we    = bus.write_en && !w_busy && addr_ok(bus.waddr);
        w_ch_commit = '0;
        w_dirty_set = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_ch_commit[i] = bus.in_en[i] && !w_busy && addr_ok(ch_addr(i));
            if (w_reg_we && bus.waddr == ch_addr(i)) w_ch_commit[i] = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (w_ch_commit[j] && ch_addr(j) == ch_addr(i)) w_ch_commit[i] = 1'b0;
            end
            w_dirty_set[i] = w_ch_commit[i] &&
                             (bus.in_data[i*SIZE +: SIZE] != r_mem[ch_addr(i)]);
        end
    end

    // Memory array: sweep writes while clearing, arbitrated writes otherwise
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == CLEAR) begin
                r_mem[r_clr_cnt] <= CLEAR_VAL;
            end else begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (w_ch_commit[i]) r_mem[ch_addr(i)] <= bus.in_data[i*SIZE +: SIZE];
                end
                if (w_reg_we) r_mem[bus.waddr] <= bus.write_data;
            end
        end
    end

    // Sticky dirty flags; a new set beats a same-edge clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dirty <= '0;
        end else if (r_state == IDLE && bus.clear_req) begin
            r_dirty <= '0;
        end else begin
            r_dirty <= (r_dirty & ~bus.in_dirty_clr) | w_dirty_set;
        end
    end

    // Drop pulse for CPU writes attempted during a sweep
    always_ff @(posedge clk) begin
        if (rst) r_write_drop <= 1'b0;
        else     r_write_drop <= bus.write_en & w_busy;
    end

    assign bus.busy       = w_busy;
    assign bus.write_drop = r_write_drop;
    assign bus.in_dirty   = r_dirty;
    assign bus.read_data  = addr_ok(bus.raddr) ? r_mem[bus.raddr] : CLEAR_VAL;
    assign bus.flag_read  = r_mem[FLAG_ADDR][0];

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in_read
        assign bus.in_read[i*SIZE +: SIZE] = addr_ok(ch_addr(i)) ? r_mem[ch_addr(i)] : CLEAR_VAL;
    end

    for (genvar w = 0; w < NUM_WIN; w++) begin : g_win
        for (genvar j = 0; j < WIN_LEN; j++) begin : g_ent
            localparam int IDX = (int'(WIN_STARTS[w*AW +: AW]) + j) % DEPTH;
            assign bus.win_read[(w*WIN_LEN+j)*SIZE +: SIZE] = r_mem[IDX];
        end
    end
endmodule
